i2s_rx: RTL and testbench

I2S_RX -- requirements
Module: i2s_rx

---
 rtl/audio_pkg.sv | 13 +
 rtl/bit_sync.sv | 26 ++
 rtl/i2s_rx.sv | 116 +++++++++++
 tb/tb_i2s_rx.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared audio definitions: sample container width and the I2S receiver state encoding.
package audio_pkg;

  localparam int AUDIO_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } i2s_state_t;

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchronizer for one asynchronous input plus a registered copy for rising-edge detection.
module bit_sync (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise
);

  logic [1:0] sync_ff;
  logic       q_prev;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_ff <= 2'b00;
      q_prev  <= 1'b0;
    end else begin
      sync_ff <= {sync_ff[0], d};
      q_prev  <= sync_ff[1];
    end
  end

  assign q    = sync_ff[1];
  assign rise = sync_ff[1] & ~q_prev;

endmodule

// File: rtl/i2s_rx.sv
// I2S receiver: deserialises left/right words into left-justified 32-bit samples.
// Optional sticky short-word flag enabled with `define I2S_RX_FRAME_ERR_EN.
module i2s_rx
  import audio_pkg::*;
#(
  parameter int SAMPLE_BITS = 24
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      AUD_BCLK,
  input  logic                      AUD_ADCLRCK,
  input  logic                      AUD_ADCDAT,
  output logic signed [AUDIO_W-1:0] audio_out_L,
  output logic signed [AUDIO_W-1:0] audio_out_R,
  output logic                      audio_valid,
  output logic                      frame_err,
  output i2s_state_t                fsm_state
);

  localparam int CNT_W = $clog2(AUDIO_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SAMPLE_BITS - 1);

  logic               bclk_s, bclk_rise;
  logic               lrck_s, lrck_rise;
  logic               dat_s, dat_rise;
  logic               unused_edges;
  i2s_state_t         state;
  logic               chan, lrck_prev, left_done, pair_pending;
  logic [CNT_W-1:0]   bit_cnt;
  logic [AUDIO_W-1:0] sr, sr_next, word_lj, hold_l, hold_r;
  logic               lrck_chg, abort, word_done;

  bit_sync u_bclk (.clock(clock), .reset(reset), .d(AUD_BCLK),    .q(bclk_s), .rise(bclk_rise));
  bit_sync u_lrck (.clock(clock), .reset(reset), .d(AUD_ADCLRCK), .q(lrck_s), .rise(lrck_rise));
  bit_sync u_dat  (.clock(clock), .reset(reset), .d(AUD_ADCDAT),  .q(dat_s),  .rise(dat_rise));

  assign unused_edges = bclk_s ^ lrck_rise ^ dat_rise;

  assign lrck_chg  = bclk_rise & (lrck_s != lrck_prev);
  assign abort     = lrck_chg & ((state == DELAY) || (state == SHIFT));
  assign sr_next   = {sr[AUDIO_W-2:0], dat_s};
  // Shifting the whole register left both drops stale upper bits and zero-pads the LSBs.
  assign word_lj   = sr_next << (AUDIO_W - SAMPLE_BITS);
  assign word_done = bclk_rise & ~lrck_chg & (state == SHIFT) & (bit_cnt == LAST_CNT);
  assign fsm_state = state;

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      chan         <= 1'b0;
      lrck_prev    <= 1'b0;
      left_done    <= 1'b0;
      pair_pending <= 1'b0;
      bit_cnt      <= '0;
      sr           <= '0;
      hold_l       <= '0;
      hold_r       <= '0;
      audio_out_L  <= '0;
      audio_out_R  <= '0;
      audio_valid  <= 1'b0;
    end else begin
      audio_valid  <= pair_pending;
      pair_pending <= 1'b0;
      if (pair_pending) begin
        audio_out_L <= hold_l;
        audio_out_R <= hold_r;
      end

      if (bclk_rise) begin
        lrck_prev <= lrck_s;
        if (lrck_chg) begin
          // The bit on the word-select edge belongs to the previous slot.
          if (abort) left_done <= 1'b0;
          chan    <= lrck_s;
          bit_cnt <= '0;
          state   <= DELAY;
        end else begin
          case (state)
            DELAY: begin
              sr      <= sr_next;
              bit_cnt <= CNT_W'(1);
              state   <= SHIFT;
            end
            SHIFT: begin
              sr      <= sr_next;
              bit_cnt <= bit_cnt + CNT_W'(1);
              if (word_done) state <= HOLD;
            end
            default: state <= state;
          endcase
        end
      end

      if (word_done) begin
        if (!chan) begin
          hold_l    <= word_lj;
          left_done <= 1'b1;
        end else begin
          hold_r       <= word_lj;
          left_done    <= 1'b0;
          pair_pending <= left_done;
        end
      end
    end
  end

`ifdef I2S_RX_FRAME_ERR_EN
  always_ff @(posedge clock) begin
    if (reset)      frame_err <= 1'b0;
    else if (abort) frame_err <= 1'b1;
  end
`else
  assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_i2s_rx.sv
// Bench for i2s_rx: drives one serial stream into a 24-bit and a 32-bit instance and scores both.
module tb_i2s_rx;
  import audio_pkg::*;

  logic clock = 1'b0;
  logic reset;
  logic AUD_BCLK, AUD_ADCLRCK, AUD_ADCDAT;

  logic signed [31:0] l24, r24, l32, r32;
  logic               v24, v32, fe24, fe32;
  i2s_state_t         st24, st32;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp24_q[$];
  logic [63:0] exp32_q[$];
  logic [63:0] hold_v[2];
  logic        prev_v[2];

`ifdef I2S_RX_FRAME_ERR_EN
  localparam logic FE_EXP = 1'b1;
`else
  localparam logic FE_EXP = 1'b0;
`endif

  typedef struct {
    logic [31:0] l_slot;
    logic [31:0] r_slot;
    logic [31:0] l24;
    logic [31:0] r24;
  } vec_t;

  vec_t vecs[4];

  i2s_rx #(.SAMPLE_BITS(24)) dut24 (
    .clock(clock), .reset(reset), .AUD_BCLK(AUD_BCLK), .AUD_ADCLRCK(AUD_ADCLRCK),
    .AUD_ADCDAT(AUD_ADCDAT), .audio_out_L(l24), .audio_out_R(r24),
    .audio_valid(v24), .frame_err(fe24), .fsm_state(st24)
  );

  i2s_rx #(.SAMPLE_BITS(32)) dut32 (
    .clock(clock), .reset(reset), .AUD_BCLK(AUD_BCLK), .AUD_ADCLRCK(AUD_ADCLRCK),
    .AUD_ADCDAT(AUD_ADCDAT), .audio_out_L(l32), .audio_out_R(r32),
    .audio_valid(v32), .frame_err(fe32), .fsm_state(st32)
  );

  // clock / reset
  initial forever #10 clock = ~clock;

  task automatic do_reset(input int n);
    @(negedge clock);
    reset = 1'b1;
    repeat (n) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // drivers: one BCLK period is 4 clocks, data/word-select change while BCLK is low
  task automatic bit_period(input logic ws, input logic d);
    @(negedge clock);
    AUD_BCLK    = 1'b0;
    AUD_ADCLRCK = ws;
    AUD_ADCDAT  = d;
    @(negedge clock);
    @(negedge clock);
    AUD_BCLK = 1'b1;
    @(negedge clock);
  endtask

  task automatic send_slot(input logic ch, input logic [31:0] w);
    bit_period(ch, 1'($urandom_range(0, 1)));
    for (int i = 31; i >= 0; i--) bit_period(ch, w[i]);
  endtask

  task automatic send_partial(input logic ch, input logic [31:0] w, input int n);
    bit_period(ch, 1'($urandom_range(0, 1)));
    for (int i = 0; i < n - 1; i++) bit_period(ch, w[31-i]);
  endtask

  task automatic idle_periods(input int n);
    for (int i = 0; i < n; i++) bit_period(AUD_ADCLRCK, 1'b0);
  endtask

  task automatic push_pair(input logic [31:0] l, input logic [31:0] r,
                           input logic [31:0] el24, input logic [31:0] er24);
    exp24_q.push_back({el24, er24});
    exp32_q.push_back({l, r});
  endtask

  task automatic send_frame(input logic [31:0] l, input logic [31:0] r);
    send_slot(1'b0, l);
    send_slot(1'b1, r);
  endtask

  // scoreboard
  task automatic mon_one(input int d);
    logic        v, fe;
    logic [63:0] act, e;
    string       sfx;
    sfx = (d == 0) ? "24" : "32";
    if (d == 0) begin v = v24; fe = fe24; act = {l24, r24}; end
    else        begin v = v32; fe = fe32; act = {l32, r32}; end
    if (reset) begin
      check({"reset_pair", sfx}, act, 64'd0);
      check({"reset_valid", sfx}, {63'd0, v}, 64'd0);
      hold_v[d] = 64'd0;
    end else if (v) begin
      check({"valid_width", sfx}, {63'd0, prev_v[d]}, 64'd0);
      if (((d == 0) ? exp24_q.size() : exp32_q.size()) == 0) begin
        check({"unexpected_pulse", sfx}, {63'd0, v}, 64'd0);
      end else begin
        e = (d == 0) ? exp24_q.pop_front() : exp32_q.pop_front();
        check({"pair", sfx}, act, e);
        hold_v[d] = e;
      end
    end else begin
      check({"hold", sfx}, act, hold_v[d]);
    end
    prev_v[d] = v;
  endtask

  task automatic monitor_loop();
    forever begin
      @(posedge clock);
      #1;
      mon_one(0);
      mon_one(1);
    end
  endtask

  task automatic check_drained(input string name);
    idle_periods(4);
    check({name, "_missed24"}, 64'(exp24_q.size()), 64'd0);
    check({name, "_missed32"}, 64'(exp32_q.size()), 64'd0);
  endtask

  initial begin
    logic [31:0] l, r;
    vecs[0] = '{32'h7FFFFF00, 32'h80000000, 32'h7FFFFF00, 32'h80000000};
    vecs[1] = '{32'h000001AB, 32'hFFFFFFCD, 32'h00000100, 32'hFFFFFF00};
    vecs[2] = '{32'h123456EF, 32'h65432110, 32'h12345600, 32'h65432100};
    vecs[3] = '{32'hA5A5A5A5, 32'h5A5A5A5A, 32'hA5A5A500, 32'h5A5A5A00};
    hold_v[0] = 64'd0; hold_v[1] = 64'd0;
    prev_v[0] = 1'b0;  prev_v[1] = 1'b0;
    reset = 1'b1;
    AUD_BCLK = 1'b0; AUD_ADCLRCK = 1'b0; AUD_ADCDAT = 1'b0;
    fork
      monitor_loop();
    join_none
    repeat (4) @(negedge clock);
    check("rst_fsm24", 64'(st24), 64'(IDLE));
    check("rst_fsm32", 64'(st32), 64'(IDLE));
    check("rst_fe24", {63'd0, fe24}, 64'd0);
    check("rst_fe32", {63'd0, fe32}, 64'd0);
    reset = 1'b0;

    // table-driven full frames, preceded by a full right slot to establish word select
    send_slot(1'b1, 32'hDEADBEEF);
    for (int i = 0; i < 4; i++) begin
      push_pair(vecs[i].l_slot, vecs[i].r_slot, vecs[i].l24, vecs[i].r24);
      send_frame(vecs[i].l_slot, vecs[i].r_slot);
    end
    check_drained("table");
    check("table_fe24", {63'd0, fe24}, 64'd0);
    check("table_fe32", {63'd0, fe32}, 64'd0);

    // stream starts mid right slot
    do_reset(2);
    send_partial(1'b1, 32'h3C3C3C3C, 15);
    push_pair(32'h00000100, 32'hFFFFFF00, 32'h00000100, 32'hFFFFFF00);
    send_frame(32'h00000100, 32'hFFFFFF00);
    check_drained("midstart");

    // left word cut short after 10 bits
    do_reset(2);
    send_slot(1'b1, 32'h0F0F0F0F);
    check("pre_short_fe24", {63'd0, fe24}, 64'd0);
    send_partial(1'b0, 32'hFFFFFFFF, 11);
    send_slot(1'b1, 32'h11111111);
    push_pair(32'h12345600, 32'h65432100, 32'h12345600, 32'h65432100);
    send_frame(32'h12345600, 32'h65432100);
    check_drained("short");
    check("short_fe24", {63'd0, fe24}, {63'd0, FE_EXP});
    check("short_fe32", {63'd0, fe32}, {63'd0, FE_EXP});

    // reset for one clock in the middle of a right word
    do_reset(2);
    send_slot(1'b1, 32'h0);
    push_pair(32'hCAFEF00D, 32'h8BADF00D, 32'hCAFEF000, 32'h8BADF000);
    send_frame(32'hCAFEF00D, 32'h8BADF00D);
    send_slot(1'b0, 32'h13579BDF);
    send_partial(1'b1, 32'h2468ACE0, 12);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("midreset_L24", 64'(l24), 64'd0);
    check("midreset_R32", 64'(r32), 64'd0);
    check("midreset_fsm24", 64'(st24), 64'(IDLE));
    @(negedge clock);
    reset = 1'b0;
    send_partial(1'b1, 32'h2468ACE0, 21);
    push_pair(32'h00FF00FF, 32'hFF00FF00, 32'h00FF0000, 32'hFF00FF00);
    send_frame(32'h00FF00FF, 32'hFF00FF00);
    check_drained("midreset");

    // random frames
    for (int i = 0; i < 150; i++) begin
      l = $urandom;
      r = $urandom;
      push_pair(l, r, l & 32'hFFFFFF00, r & 32'hFFFFFF00);
      send_frame(l, r);
    end
    check_drained("random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
